mem_bus_arbiter: RTL

//  Shares the single external memory port between the instruction-fetch path
//  (code reads) and the execute path (MOVX/MOVC data reads and writes).

---
 rtl/mem_bus_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and execute.
// Exec normally wins; a streak limit guarantees fetch progress. Stalled transfers time out.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 15,
    parameter int MAX_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_done,
    input  logic              exec_req,
    input  logic              exec_we,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [DATA_W-1:0] exec_wdata,
    output logic              exec_done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int STK_W = $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_E} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [STK_W-1:0]  streak_reg, streak_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              bus_err_reg, bus_err_next;
    logic              fetch_done_reg, fetch_done_next;
    logic              exec_done_reg, exec_done_next;
    logic              finish;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            streak_reg     <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            rdata_reg      <= '0;
            bus_err_reg    <= 1'b0;
            fetch_done_reg <= 1'b0;
            exec_done_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            streak_reg     <= streak_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            rdata_reg      <= rdata_next;
            bus_err_reg    <= bus_err_next;
            fetch_done_reg <= fetch_done_next;
            exec_done_reg  <= exec_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        streak_next     = streak_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        rdata_next      = rdata_reg;
        bus_err_next    = bus_err_reg;
        fetch_done_next = 1'b0;
        exec_done_next  = 1'b0;
        finish          = 1'b0;

        case (state_reg)
            IDLE: begin
                mem_req_next = 1'b0;
                cnt_next     = '0;
                if (exec_req && !(fetch_req && streak_reg == STK_MAX)) begin
                    mem_req_next   = 1'b1;
                    mem_we_next    = exec_we;
                    mem_addr_next  = exec_addr;
                    mem_wdata_next = exec_wdata;
                    if (!fetch_req)
                        streak_next = '0;
                    else if (streak_reg != STK_MAX)
                        streak_next = streak_reg + 1'b1;
                    state_next = BUSY_E;
                end else if (fetch_req) begin
                    mem_req_next  = 1'b1;
                    mem_we_next   = 1'b0;
                    mem_addr_next = fetch_addr;
                    streak_next   = '0;
                    state_next    = BUSY_F;
                end
            end
            BUSY_F, BUSY_E: begin
                // An ack in the timeout cycle wins: it is checked first.
                if (mem_ack) begin
                    finish       = 1'b1;
                    bus_err_next = 1'b0;
                    if (!mem_we_reg)
                        rdata_next = mem_rdata;
                end else if (cnt_reg == CNT_LAST) begin
                    finish       = 1'b1;
                    bus_err_next = 1'b1;
                    if (!mem_we_reg)
                        rdata_next = '1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (finish) begin
                    mem_req_next    = 1'b0;
                    cnt_next        = '0;
                    fetch_done_next = (state_reg == BUSY_F);
                    exec_done_next  = (state_reg == BUSY_E);
                    state_next      = IDLE;
                end
            end
            default: begin
                mem_req_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign rdata      = rdata_reg;
    assign bus_err    = bus_err_reg;
    assign fetch_done = fetch_done_reg;
    assign exec_done  = exec_done_reg;

endmodule
